// File: rtl/lea_pkg.sv
// lea_pkg: shared constants, state encoding and word-slice helpers for the LEA round unit.
package lea_pkg;
   localparam int LEA_WORD = 32;
   localparam int ROT_A = 9;
   localparam int ROT_B = 5;
   localparam int ROT_C = 3;
   typedef enum logic [1:0] {IDLE, ADD0, ADD1, ADD2} state_t;
   function automatic logic [31:0] w128(input logic [127:0] bus, input int k);
      return bus[32*k +: 32];
   endfunction
   function automatic logic [31:0] w192(input logic [191:0] bus, input int k);
      return bus[32*k +: 32];
   endfunction
   function automatic logic [31:0] rol(input logic [31:0] v, input int n);
      return (v << n) | (v >> (LEA_WORD - n));
   endfunction
   function automatic logic [31:0] ror(input logic [31:0] v, input int n);
      return (v >> n) | (v << (LEA_WORD - n));
   endfunction
endpackage

// File: rtl/lea_add32.sv
// lea_add32: 32-bit ripple adder from full-adder cells, carry-in 0, carry-out dropped.
module lea_add32 (
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] S
);
   logic [31:0] c;
   assign c[0] = 1'b0;
   for (genvar i = 0; i < 32; i++) begin : g_fa
      assign S[i] = A[i] ^ B[i] ^ c[i];
      if (i < 31) begin : g_c
         assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
      end
   end
endmodule

// File: rtl/lea_round_unit.sv
// lea_round_unit: one LEA encryption round over three cycles on a single shared adder.
module lea_round_unit
   import lea_pkg::*;
#(
   parameter int WORD = LEA_WORD
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         START,
   input  logic [127:0] X_IN,
   input  logic [191:0] RK_IN,
   output logic         BUSY,
   output logic         DONE,
   output logic [127:0] X_OUT
);
   if (WORD != 32) begin : g_bad_word
      $error("lea_round_unit: WORD must be 32");
   end
   state_t st;
   logic [127:0] x;
   logic [191:0] rk;
   logic [31:0] t0, t1, a, b, s;
   logic [127:0] xo;
   always_comb begin
      a = st == ADD0 ? w128(x, 0) ^ w192(rk, 0) : st == ADD1 ? w128(x, 1) ^ w192(rk, 2) : w128(x, 2) ^ w192(rk, 4);
      b = st == ADD0 ? w128(x, 1) ^ w192(rk, 1) : st == ADD1 ? w128(x, 2) ^ w192(rk, 3) : w128(x, 3) ^ w192(rk, 5);
   end
   lea_add32 u_add (.A(a), .B(b), .S(s));
   // During ADD2 the result is presented straight from the adder so DONE and X_OUT coincide.
   assign X_OUT = DONE ? {w128(x, 0), ror(s, ROT_C), t1, t0} : xo;
   always_ff @(posedge CLK) begin
      if (RST) begin
         st   <= IDLE;
         BUSY <= 1'b0;
         DONE <= 1'b0;
         xo   <= '0;
      end else begin
         DONE <= st == ADD1;
         BUSY <= (st == IDLE && START) || st == ADD0 || st == ADD1;
         case (st)
            IDLE: if (START) begin
               x  <= X_IN;
               rk <= RK_IN;
               st <= ADD0;
            end
            ADD0: begin
               t0 <= rol(s, ROT_A);
               st <= ADD1;
            end
            ADD1: begin
               t1 <= ror(s, ROT_B);
               st <= ADD2;
            end
            ADD2: begin
               xo <= {w128(x, 0), ror(s, ROT_C), t1, t0};
               st <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/lea_round_unit.md
Name: lea_round_unit

Overview:
- Computes one LEA encryption round on a 128-bit state, given six 32-bit round-key words.
- Sits directly downstream of the full-adder cell. All modular additions go through one shared 32-bit ripple adder built from that cell, used once per cycle.
- Driven by the LEA round controller and key schedule with a START/DONE handshake. Three addition cycles per round.

Parameters:
- WORD, 32, word width in bits; 32 is the only legal value, and elaboration fails on any other.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; accepted only when BUSY=0.
- X_IN  input  128  state: [31:0]=X0, [63:32]=X1, [95:64]=X2, [127:96]=X3.
- RK_IN  input  192  round key: [32k+31:32k]=RKk, k=0..5.
- BUSY  output  1  high while a round is in progress.
- DONE  output  1  single-cycle pulse when X_OUT becomes valid.
- X_OUT  output  128  next state, same word packing as X_IN.

Behaviour:
- Reset:
  - State is IDLE; BUSY=0, DONE=0, X_OUT=0.
  - RST wins over START in the same cycle.
  - RST mid-round aborts the round, discards partial results and returns to IDLE with the above output values.
- Round function (all additions mod 2^32, carry-out discarded, adder carry-in tied 0):
  - T0 = ROL9((X0^RK0)+(X1^RK1))
  - T1 = ROR5((X1^RK2)+(X2^RK3))
  - T2 = ROR3((X2^RK4)+(X3^RK5))
  - T3 = X0
- State machine IDLE -> ADD0 -> ADD1 -> ADD2 -> IDLE:
  - IDLE: on START=1, latch X_IN and RK_IN into internal registers, set BUSY=1, go to ADD0. Inputs are not sampled again until the next accepted START.
  - ADD0: adder operands are (X0^RK0, X1^RK1); register T0.
  - ADD1: adder operands are (X1^RK2, X2^RK3); register T1.
  - ADD2: adder operands are (X2^RK4, X3^RK5); T2 is formed. X_OUT is loaded with {T3,T2,T1,T0}. DONE=1 for exactly this one cycle, next state IDLE.
- Timing:
  - BUSY=1 in ADD0, ADD1, ADD2 and is registered. It deasserts the cycle after DONE.
  - Latency: START sampled at edge n -> DONE high during cycle n+3, X_OUT valid from the same cycle.
  - X_OUT holds its value until the next DONE. It does not change on START or while BUSY.
- START rules:
  - START while BUSY=1 is ignored: no queueing, no effect on the round in progress.
  - START held high continuously starts a new round in the first IDLE cycle, giving back-to-back rounds every 4 cycles.
- X_IN/RK_IN changes after acceptance have no effect.
- Rotations are fixed wiring; the only arithmetic element is the shared adder.

Decomposition:
- Shared package lea_pkg:
  - LEA_WORD=32.
  - Rotation constants ROT_A=9 (left), ROT_B=5 (right), ROT_C=3 (right).
  - State encoding IDLE/ADD0/ADD1/ADD2 (2-bit).
  - Word-slice index helpers for the 128-bit and 192-bit buses.
- One sub-module, lea_add32:
  - 32-bit combinational ripple adder, a chain of 32 full-adder cells.
  - Carry-in tied 0, carry-out unused.
  - Ports A[31:0], B[31:0], S[31:0].

Test Plan:
- Reset: hold RST 2 cycles with START=1 -> BUSY=0, DONE=0, X_OUT=0; no round starts.
- Basic round: X0=1, X1=X2=X3=0, RK=0; pulse START -> DONE exactly 3 cycles later, X_OUT = X3:00000001, X2:00000000, X1:00000000, X0:00000200.
- Carry wrap plus XOR plus rotations:
  - Stimulus: X0=FFFFFFFF, X1=00000001, X2=00000008, X3=0, RK2=00000001, other RK=0.
  - Expected T0=0 (sum wraps to 0). T1 is ROR5 of (0+8), i.e. 40000000. T2 is ROR3 of (8+0), i.e. 00000001. T3=FFFFFFFF.
  - X_OUT = {FFFFFFFF,00000001,40000000,00000000}.
- START while busy: pulse START again in ADD1 with different X_IN -> ignored. DONE once, with first-round result. BUSY drops the next cycle.
- Reset mid-round: assert RST in ADD1 -> next cycle IDLE, BUSY=0, X_OUT=0, no DONE. A following START completes normally in 3 cycles.
- Back-to-back: START held high for 3 rounds with fixed inputs -> DONE pulses 4 cycles apart. X_OUT is stable between pulses and matches the reference model each time.
